// File: rtl/regfile_alu_sequencer.sv
// Multi-cycle controller for an 8-entry register file. It runs one two-source
// ALU micro-op per start and arbitrates external preload writes onto the write port.
module regfile_alu_sequencer #(
  parameter int N = 8,
  parameter int A = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [A-1:0] src_a,
  input  logic [A-1:0] src_b,
  input  logic [A-1:0] dst,
  input  logic         ld_req,
  input  logic [A-1:0] ld_addr,
  input  logic [N-1:0] ld_data,
  output logic         ld_ack,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic [A-1:0] rf_ra1,
  output logic [A-1:0] rf_ra2,
  input  logic [N-1:0] rf_rd1,
  input  logic [N-1:0] rf_rd2,
  output logic [A-1:0] rf_wa3,
  output logic [N-1:0] rf_wd3,
  output logic         rf_we3
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WRITE, DONE, LOAD} state_t;

  state_t       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [A-1:0] dst_q, dst_d;
  logic [A-1:0] ra1_q, ra1_d, ra2_q, ra2_d;
  logic [N-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [N-1:0] result_q, result_d;
  logic         ovf_q, ovf_d;
  logic         busy_q, busy_d, done_q, done_d, ld_ack_q, ld_ack_d;
  logic         we_q, we_d;
  logic [A-1:0] wa_q, wa_d;
  logic [N-1:0] wd_q, wd_d;
  logic [N-1:0] alu_res;
  logic         alu_ovf;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      2'b00: begin
        alu_res = opa_q + opb_q;
        alu_ovf = (opa_q[N-1] == opb_q[N-1]) && (alu_res[N-1] != opa_q[N-1]);
      end
      2'b01: begin
        alu_res = opa_q - opb_q;
        alu_ovf = (opa_q[N-1] != opb_q[N-1]) && (alu_res[N-1] != opa_q[N-1]);
      end
      2'b10: alu_res = opa_q & opb_q;
      default: alu_res = opa_q | opb_q;
    endcase
  end

  // Outputs are computed one state ahead so every port comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    ra1_d    = ra1_q;
    ra2_d    = ra2_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    ld_ack_d = 1'b0;
    we_d     = 1'b0;
    wa_d     = '0;
    wd_d     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          op_d    = op;
          ra1_d   = src_a;
          ra2_d   = src_b;
          dst_d   = dst;
        end else if (ld_req) begin
          state_d  = LOAD;
          we_d     = 1'b1;
          wa_d     = ld_addr;
          wd_d     = ld_data;
          ld_ack_d = 1'b1;
        end
      end
      FETCH: begin
        opa_d   = rf_rd1;
        opb_d   = rf_rd2;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_res;
        ovf_d    = alu_ovf;
        we_d     = 1'b1;
        wa_d     = dst_q;
        wd_d     = alu_res;
        state_d  = WRITE;
      end
      WRITE: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      ra1_q    <= '0;
      ra2_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ld_ack_q <= 1'b0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      ra1_q    <= ra1_d;
      ra2_q    <= ra2_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ld_ack_q <= ld_ack_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  assign ld_ack = ld_ack_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign rf_ra1 = ra1_q;
  assign rf_ra2 = ra2_q;
  assign rf_we3 = we_q;
  assign rf_wa3 = wa_q;
  assign rf_wd3 = wd_q;

endmodule

// File: doc/regfile_alu_sequencer.md
Name: regfile_alu_sequencer

Overview:
- Multi-cycle controller that owns all ports of the 8-entry RegisterFile (3-bit addresses, N-bit data): the two read ports ra1/rd1 and ra2/rd2, and the write port wa3/wd3/we3.
- Executes one register-to-register ALU micro-operation per start: read two source registers, compute add/sub/and/or, write the result to a destination register.
- Also arbitrates an external preload write request onto the single write port.
- Sits between switch/key user logic and the RegisterFile instance.

Parameters:
- N, 8, data width of registers, operands and result.
- A, 3, register address width (2^A registers).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one ALU operation; sampled only in IDLE.
- op  in  2  operation: 00 add, 01 sub (a-b), 10 and, 11 or.
- src_a  in  A  first source register address.
- src_b  in  A  second source register address.
- dst  in  A  destination register address.
- ld_req  in  1  level request to write ld_data into ld_addr.
- ld_addr  in  A  preload destination address.
- ld_data  in  N  preload data.
- ld_ack  out  1  one-cycle pulse; preload written on this cycle's clock edge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an ALU operation completes.
- result  out  N  last computed result, held between operations.
- ovf  out  1  signed overflow of the last add/sub; 0 for and/or.
- rf_ra1  out  A  to RegisterFile ra1.
- rf_ra2  out  A  to RegisterFile ra2.
- rf_rd1  in  N  from RegisterFile rd1; combinational in ra1.
- rf_rd2  in  N  from RegisterFile rd2; combinational in ra2.
- rf_wa3  out  A  to RegisterFile wa3.
- rf_wd3  out  N  to RegisterFile wd3.
- rf_we3  out  1  to RegisterFile we3; write happens on the clk edge while high.

Behaviour:
- States: IDLE, FETCH, EXEC, WRITE, DONE, LOAD. All state and output registers update on the rising edge of clk.
- Reset (rst=1 at an edge) forces IDLE. Reset values: busy=0, done=0, ld_ack=0, result=0, ovf=0, rf_we3=0, rf_wa3=0, rf_wd3=0, rf_ra1=0, rf_ra2=0, all latched fields 0. Register contents are not cleared by this block.
- Reset mid-operation aborts immediately. No rf_we3 pulse, done or ld_ack is produced for the aborted operation.
- IDLE:
  - start=1 → latch op/src_a/src_b/dst, go to FETCH.
  - else ld_req=1 → latch ld_addr/ld_data, go to LOAD.
  - start has priority when both are high. ld_req stays pending and is served on the next return to IDLE.
- FETCH: rf_ra1=latched src_a, rf_ra2=latched src_b. At the edge, capture rf_rd1/rf_rd2 into operand registers opa/opb. Go to EXEC.
- EXEC: compute into result/ovf at the edge, modulo 2^N. Go to WRITE.
  - add: result=opa+opb; ovf=(opa[N-1]==opb[N-1]) && (result[N-1]!=opa[N-1]).
  - sub: result=opa-opb; ovf=(opa[N-1]!=opb[N-1]) && (result[N-1]!=opa[N-1]).
  - and/or: bitwise; ovf=0.
- WRITE: rf_we3=1, rf_wa3=latched dst, rf_wd3=result for exactly one cycle. Go to DONE.
- DONE: done=1 for one cycle. Go to IDLE.
- LOAD: rf_we3=1, rf_wa3=latched ld_addr, rf_wd3=latched ld_data, ld_ack=1, all for one cycle. Go to IDLE.
  - A requester holding ld_req high after ld_ack is treated as a new request.
- Outside WRITE/LOAD: rf_we3=0, rf_wa3=0, rf_wd3=0.
- rf_ra1/rf_ra2 hold the last latched src_a/src_b in all states.
- Latency: start sampled in IDLE at edge k; FETCH occupies cycle k+1 and done is high during cycle k+4. The destination register is updated at the WRITE→DONE edge. Throughput is one operation per 5 cycles.
- Inputs start/op/src/dst/ld_* are ignored while busy=1, except that ld_req is re-sampled in IDLE.
- dst equal to src_a or src_b is legal: operands are captured in FETCH, before the write.
- Identical src_a and src_b are legal.
- Any address value including 0 is legal; register 0 is not special.

Test Plan:
- Preload: ld_req with R1=0x05, then R2=0x03 → ld_ack pulses one cycle after each acceptance. Then start add src_a=1, src_b=2, dst=3 → done four cycles after start is sampled, result=0x08, ovf=0; reading R3 returns 0x08.
- Overflow: R1=0x7F, R2=0x01, add → result=0x80, ovf=1. R1=0x80, R2=0x01, sub → result=0x7F, ovf=1. R1=0x05, R2=0x07, sub → 0xFE, ovf=0.
- In-place and: R1=0xF0, R2=0x3C, op=and, dst=1 → R1=0x30. Then op=or src_a=1 src_b=1 dst=4 → R4=0x30.
- Arbitration: start and ld_req high on the same IDLE cycle → ALU op completes first (done). ld_ack follows on the cycle after returning to IDLE. Start pulses during busy produce no extra done.
- Reset in EXEC: assert rst for one cycle → busy=0 next cycle, no rf_we3 pulse, destination register unchanged, result=0.
- Back-to-back: start held high continuously → done every 5 cycles, each result written to the correct dst.
